// File: rtl/m10k_row_transposer.sv
// m10k_row_transposer: reads an MxN matrix from the row memory, buffers it,
// and writes the transpose back; owns both memory ports while busy.
module m10k_row_transposer #(
    parameter int DATA_LEN     = 32,
    parameter int M            = 8,
    parameter int N            = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int SRC_BASE     = 0,
    parameter int DST_BASE     = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [ADDRESS_SIZE-1:0]   o_rd_addr,
    input  logic [DATA_LEN*N-1:0]     i_rd_data,
    output logic [ADDRESS_SIZE-1:0]   o_wr_addr,
    output logic [DATA_LEN*N-1:0]     o_wr_data,
    output logic                      o_wr_en
);
    localparam int ROW_W = DATA_LEN * N;
    localparam int CW    = $clog2(N + 1);
    localparam int DEPTH = 1 << ADDRESS_SIZE;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    generate
        if (M != N) begin : g_bad_shape
            $error("m10k_row_transposer: M must equal N");
        end
        if ((SRC_BASE + M > DEPTH) || (DST_BASE + N > DEPTH)) begin : g_bad_fit
            $error("m10k_row_transposer: row range exceeds memory");
        end
        if (!((SRC_BASE + M <= DST_BASE) || (DST_BASE + N <= SRC_BASE))) begin : g_bad_ovl
            $error("m10k_row_transposer: source and destination overlap");
        end
    endgenerate

    logic [2:0]              state_q, state_d;
    logic [ADDRESS_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [ADDRESS_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
    logic [ROW_W-1:0]        wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [ROW_W-1:0]        row_buf_q [M];
    logic                    cap_en;
    logic [CW-1:0]           cap_idx;
    logic [CW-1:0]           col_sel;
    logic [ROW_W-1:0]        col_d;

    // Column gather; in DRAIN the last row is still on the read bus.
    always_comb begin
        col_sel = (state_q == WRITE) ? wr_cnt_q + CW'(1) : '0;
        col_d   = '0;
        for (int j = 0; j < N; j++) begin
            if (col_sel == CW'(j)) begin
                for (int i = 0; i < M; i++) begin
                    col_d[i*DATA_LEN +: DATA_LEN] = row_buf_q[i][j*DATA_LEN +: DATA_LEN];
                end
            end
        end
        if (state_q == DRAIN) begin
            col_d[(M-1)*DATA_LEN +: DATA_LEN] = i_rd_data[DATA_LEN-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wr_data_d = wr_data_q;
        wr_en_d   = wr_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cap_en    = 1'b0;
        cap_idx   = rd_cnt_q - CW'(1);
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = READ;
                    rd_addr_d = ADDRESS_SIZE'(SRC_BASE);
                    rd_cnt_d  = '0;
                    busy_d    = 1'b1;
                end
            end
            READ: begin
                cap_en = (rd_cnt_q != '0);
                if (rd_cnt_q == CW'(M - 1)) begin
                    state_d = DRAIN;
                end else begin
                    rd_cnt_d  = rd_cnt_q + CW'(1);
                    rd_addr_d = rd_addr_q + ADDRESS_SIZE'(1);
                end
            end
            DRAIN: begin
                cap_en    = 1'b1;
                cap_idx   = CW'(M - 1);
                state_d   = WRITE;
                wr_en_d   = 1'b1;
                wr_addr_d = ADDRESS_SIZE'(DST_BASE);
                wr_cnt_d  = '0;
                wr_data_d = col_d;
            end
            WRITE: begin
                if (wr_cnt_q == CW'(N - 1)) begin
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wr_cnt_d  = wr_cnt_q + CW'(1);
                    wr_addr_d = wr_addr_q + ADDRESS_SIZE'(1);
                    wr_data_d = col_d;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            rd_addr_q <= ADDRESS_SIZE'(SRC_BASE);
            wr_addr_q <= ADDRESS_SIZE'(DST_BASE);
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Row buffer is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < M; i++) begin
            if (cap_en && (cap_idx == CW'(i))) begin
                row_buf_q[i] <= i_rd_data;
            end
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rd_addr = rd_addr_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_wr_en   = wr_en_q;

endmodule

// File: tb/tb_m10k_row_transposer.sv
// Bench for m10k_row_transposer: row memory model plus a write scoreboard
// fed by the stimulus side and drained by an independent write monitor.
module tb_m10k_row_transposer;
    localparam int DL = 32;
    localparam int NN = 8;
    localparam int AW = 4;
    localparam int RW = DL * NN;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [RW-1:0] d;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic          wr_en;

    logic [RW-1:0] mem [16];
    logic [RW-1:0] src [NN];
    logic          load_req;

    wr_t sb_q[$];
    int  pass_cnt = 0;
    int  tot_cnt  = 0;

    m10k_row_transposer dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .o_wr_en   (wr_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read dual-port row memory; load_req reloads src and clears dst.
    always @(posedge clk) begin
        if (load_req) begin
            for (int r = 0; r < 16; r++) begin
                mem[r] <= (r < NN) ? src[r] : '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        tot_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] tcol(input int j);
        logic [RW-1:0] d;
        for (int i = 0; i < NN; i++) begin
            d[i*DL +: DL] = src[i][j*DL +: DL];
        end
        return d;
    endfunction

    task automatic push_expected();
        wr_t e;
        for (int j = 0; j < NN; j++) begin
            e.a = AW'(8 + j);
            e.d = tcol(j);
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            if (sb_q.size() == 0) begin
                tot_cnt++;
                $display("FAIL unexpected_write: got addr %0d want none", wr_addr);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", RW'(wr_addr), RW'(e.a));
                chk("wr_data", wr_data, e.d);
            end
        end
    end

    task automatic load_mem();
        @(posedge clk);
        #1 load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic check_mem(input int ndst);
        for (int r = 0; r < NN; r++) begin
            chk("src_row_kept", mem[r], src[r]);
        end
        for (int j = 0; j < NN; j++) begin
            chk("dst_row", mem[8+j], (j < ndst) ? tcol(j) : '0);
        end
    endtask

    task automatic do_run();
        push_expected();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk("busy", RW'(busy), RW'(1));
            chk("done", RW'(done), RW'(k == 18));
            chk("wr_en", RW'(wr_en), RW'(k >= 10 && k <= 17));
            chk("rd_addr", RW'(rd_addr), RW'((k <= 8) ? k - 1 : 7));
        end
        @(negedge clk);
        chk("busy_after", RW'(busy), RW'(0));
        chk("done_after", RW'(done), RW'(0));
        chk("sb_empty", RW'(sb_q.size()), RW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        load_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", RW'(busy), RW'(0));
        chk("rst_done", RW'(done), RW'(0));
        chk("rst_wr_en", RW'(wr_en), RW'(0));
        chk("rst_rd_addr", RW'(rd_addr), RW'(0));
        chk("rst_wr_addr", RW'(wr_addr), RW'(8));
        chk("rst_wr_data", wr_data, '0);

        for (int r = 0; r < NN; r++) begin
            for (int c = 0; c < NN; c++) begin
                src[r][c*DL +: DL] = DL'(8 * r + c);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        load_mem();
        do_run();
        check_mem(NN);
        chk("row8_hand", mem[8],
            256'h00000038_00000030_00000028_00000020_00000018_00000010_00000008_00000000);
        chk("row15_hand", mem[15],
            256'h0000003f_00000037_0000002f_00000027_0000001f_00000017_0000000f_00000007);

        load_mem();
        push_expected();
        push_expected();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            chk("b2b_done", RW'(done), RW'(k == 18 || k == 37));
            chk("b2b_busy", RW'(busy), RW'(k != 19));
            chk("b2b_wr_en", RW'(wr_en),
                RW'((k >= 10 && k <= 17) || (k >= 29 && k <= 36)));
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("b2b_idle", RW'(busy), RW'(0));
        end
        chk("b2b_sb_empty", RW'(sb_q.size()), RW'(0));
        check_mem(NN);

        load_mem();
        push_expected();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("abort_no_done", RW'(done), RW'(0));
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_wr_en", RW'(wr_en), RW'(0));
        chk("abort_busy", RW'(busy), RW'(0));
        chk("abort_done", RW'(done), RW'(0));
        chk("abort_wr_addr", RW'(wr_addr), RW'(8));
        chk("abort_rd_addr", RW'(rd_addr), RW'(0));
        chk("abort_wr_data", wr_data, '0);
        chk("abort_sb_left", RW'(sb_q.size()), RW'(5));
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check_mem(3);
        rst = 1'b0;
        do_run();
        check_mem(NN);

        for (int r = 0; r < NN; r++) begin
            for (int c = 0; c < NN; c++) begin
                src[r][c*DL +: DL] = $urandom;
            end
        end
        load_mem();
        do_run();
        check_mem(NN);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
